stage3_pow2_arbiter: RTL and testbench
======================================

STAGE3_POW2_ARBITER -- requirements
Module: stage3_pow2_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one pow2 pipeline unit.
REQ-002 Parameter PU_LAT, default 2, SHALL equal the pow2 unit's latency in enabled cycles.
REQ-003 i_clk  in  1  single clock; i_rst  in  1  reset, synchronous and active-high.
REQ-004 i_en  in  1  global enable; low SHALL freeze all state and force o_pu_en low.
REQ-005 i_req_valid  in  NUM_REQ  per-requester valid; i_req_x  in  NUM_REQ*16  per-requester Q6.10 operand, requester k at bits [16k+15:16k].
REQ-006 o_req_ready  out  NUM_REQ  one-hot grant/accept; transfer when valid & ready.
REQ-007 o_pu_en, o_pu_valid  out  1 each  pow2 unit enable and input valid; o_pu_x  out  16  pow2 unit operand.
REQ-008 i_pu_valid  in  1, i_pu_pow_x  in  16, i_pu_x_byp  in  16  pow2 unit outputs.
REQ-009 o_rsp_valid  out  NUM_REQ  one-hot response valid; o_rsp_pow_x, o_rsp_x  out  16 each  shared result/bypass bus; i_rsp_ready  in  NUM_REQ  per-requester sink ready.
REQ-010 o_busy  out  1  high while any issued operand has not been delivered.

Function
REQ-011 o_pu_en SHALL be i_en & !(i_pu_valid & !i_rsp_ready[tag_out]), where tag_out is the requester tag at the pipeline tail.
REQ-012 In a cycle with o_pu_en high, the arbiter SHALL grant at most one requester with i_req_valid high, chosen round-robin starting from pointer rr_ptr.
REQ-013 o_req_ready SHALL be zero whenever o_pu_en is low; no operand SHALL be consumed during a stall.
REQ-014 o_pu_valid SHALL equal |o_req_ready; o_pu_x SHALL carry the granted operand, and 16'h0000 when no grant.
REQ-015 On a grant to index g, rr_ptr SHALL become (g+1) mod NUM_REQ; with no grant, rr_ptr SHALL hold.
REQ-016 A tag shift register of PU_LAT entries (valid bit + index) SHALL advance only when o_pu_en is high, inserting {o_pu_valid, g}.
REQ-017 o_rsp_valid[k] SHALL be i_pu_valid & tail-valid & (tag_out==k); all other bits zero.
REQ-018 o_rsp_pow_x and o_rsp_x SHALL pass i_pu_pow_x and i_pu_x_byp unchanged.
REQ-019 A held response (sink not ready) SHALL remain stable with identical data until accepted.
REQ-020 An in-flight counter SHALL increment on grant and decrement on response accept; simultaneous grant and accept SHALL leave it unchanged; o_busy = counter != 0.
REQ-021 Counter width SHALL be clog2(PU_LAT+1)+1 and never overflow, since grants stall with the pipeline.
REQ-022 Per-requester order SHALL be preserved; results SHALL emerge PU_LAT enabled cycles after issue.

Reset
REQ-023 On i_rst: rr_ptr=0, all tag entries invalid with index 0, in-flight counter=0.
REQ-024 During reset, o_req_ready=0, o_pu_valid=0, o_rsp_valid=0, o_busy=0; o_pu_en SHALL equal i_en, so that the pow2 unit, held in reset alongside, flushes.
REQ-025 Reset mid-operation SHALL discard all in-flight operands without delivering them.

Structure
REQ-026 A shared package SHALL hold the data width (16), default NUM_REQ and PU_LAT, and the tag-entry struct {valid, index}.
REQ-027 Round-robin selection SHALL be a sub-module rr_grant (inputs request vector, pointer, enable; output one-hot grant).
REQ-028 The pow2 unit SHALL be instantiated outside this block and shared via the o_pu_*/i_pu_* ports.

Verification
REQ-029 Single requester 0, x=16'h0000, all sinks ready -> o_rsp_valid=4'b0001 two cycles later, o_rsp_pow_x=16'h0400.
REQ-030 All four valid continuously, x=16'h1400 -> grants 0,1,2,3,0 on consecutive cycles; every response is 16'h8000, routed to the matching index.
REQ-031 Requester 2 sink ready low for 5 cycles while its result is at the tail -> o_pu_en=0, o_req_ready=0, response held stable, released in the cycle ready rises.
REQ-032 i_en low for 3 cycles mid-stream -> no grants, rr_ptr and tags frozen, stream resumes without loss or duplication.
REQ-033 i_rst asserted with 2 operands in flight -> no o_rsp_valid afterwards, o_busy=0 the following cycle, first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/stage3_pow2_arbiter_pkg.sv
// Shared types and sizing for the pow2 request arbiter.
package stage3_pow2_arbiter_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_PU_LAT  = 2;
  localparam int unsigned TAG_IDX_W   = 8;

  // Pipeline tag entry: which requester owns the operand in a given stage.
  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/stage3_pow2_arbiter_rr_grant.sv
// Round-robin one-hot grant: first asserted request at or after the pointer.
module rr_grant #(
  parameter int unsigned N = 4,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PTR_W'((32'(ptr_i) + k) % N);
      if (en_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stage3_pow2_arbiter.sv
// Shares one external pow2 pipeline among NUM_REQ requesters, routing each
// result back to its issuer through a tag pipe that mirrors the unit latency.
module stage3_pow2_arbiter
  import stage3_pow2_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned PU_LAT  = DEF_PU_LAT
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_x,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_pu_en,
  output logic                      o_pu_valid,
  output logic [DATA_W-1:0]         o_pu_x,
  input  logic                      i_pu_valid,
  input  logic [DATA_W-1:0]         i_pu_pow_x,
  input  logic [DATA_W-1:0]         i_pu_x_byp,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_pow_x,
  output logic [DATA_W-1:0]         o_rsp_x,
  input  logic [NUM_REQ-1:0]        i_rsp_ready,
  output logic                      o_busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(PU_LAT + 1) + 1;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  tag_t               tag_q [PU_LAT];
  tag_t               tail;
  logic [PTR_W-1:0]   tag_out;
  logic [PTR_W-1:0]   gidx;
  logic [NUM_REQ-1:0] gnt;
  logic [DATA_W-1:0]  pu_x;
  logic [NUM_REQ-1:0] rsp_valid;
  logic               accept;

  assign tail    = tag_q[PU_LAT-1];
  assign tag_out = PTR_W'(tail.idx);

  // Stall the whole pipe while the tail result waits on its sink; reset lets
  // the enable through so the external unit flushes alongside.
  assign o_pu_en = i_en & (i_rst | ~(i_pu_valid & ~i_rsp_ready[tag_out]));

  rr_grant #(.N(NUM_REQ)) u_rr_grant (
    .req_i (i_req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (o_pu_en & ~i_rst),
    .gnt_o (gnt)
  );

  always_comb begin
    pu_x = '0;
    gidx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        pu_x = i_req_x[DATA_W*k +: DATA_W];
        gidx = PTR_W'(k);
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (!i_rst && i_pu_valid && tail.valid) rsp_valid[tag_out] = 1'b1;
  end

  assign accept = o_pu_en & (|(rsp_valid & i_rsp_ready));

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|gnt) rr_ptr_d = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);
    cnt_d = cnt_q;
    case ({|gnt, accept})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < PU_LAT; i++) tag_q[i] <= '0;
    end else if (o_pu_en) begin
      rr_ptr_q        <= rr_ptr_d;
      cnt_q           <= cnt_d;
      tag_q[0].valid  <= |gnt;
      tag_q[0].idx    <= TAG_IDX_W'(gidx);
      for (int unsigned i = 1; i < PU_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign o_req_ready = gnt;
  assign o_pu_valid  = |gnt;
  assign o_pu_x      = pu_x;
  assign o_rsp_valid = rsp_valid;
  assign o_rsp_pow_x = i_pu_pow_x;
  assign o_rsp_x     = i_pu_x_byp;
  assign o_busy      = ~i_rst & (cnt_q != '0);

endmodule

// File: tb/tb_stage3_pow2_arbiter.sv
// Directed bench for stage3_pow2_arbiter with a 2-stage pow2 unit model.
module tb_stage3_pow2_arbiter;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_x;
  logic        pu_en, pu_valid_o, pu_valid_i, busy;
  logic [15:0] pu_x, pu_pow, pu_byp, rsp_pow, rsp_x;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage3_pow2_arbiter #(.NUM_REQ(4), .PU_LAT(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_req_valid(req_valid), .i_req_x(req_x), .o_req_ready(req_ready),
    .o_pu_en(pu_en), .o_pu_valid(pu_valid_o), .o_pu_x(pu_x),
    .i_pu_valid(pu_valid_i), .i_pu_pow_x(pu_pow), .i_pu_x_byp(pu_byp),
    .o_rsp_valid(rsp_valid), .o_rsp_pow_x(rsp_pow), .o_rsp_x(rsp_x),
    .i_rsp_ready(rsp_ready), .o_busy(busy)
  );

  // External pow2 unit model: 2 enabled cycles, integer-exponent operands only.
  logic [1:0]  m_v;
  logic [15:0] m_x0, m_x1;
  always @(posedge clk) begin
    if (rst) begin
      m_v <= '0; m_x0 <= '0; m_x1 <= '0;
    end else if (pu_en) begin
      m_v  <= {m_v[0], pu_valid_o};
      m_x0 <= pu_x;
      m_x1 <= m_x0;
    end
  end
  assign pu_valid_i = m_v[1];
  assign pu_byp     = m_x1;
  assign pu_pow     = 16'h0400 << m_x1[15:10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] rq, input logic [3:0] rd);
    @(negedge clk);
    rst = r; en = e; req_valid = rq; rsp_ready = rd;
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [3:0]  rdy;
    logic [15:0] x;
    logic [3:0]  e_ready;
    logic        e_pu_en;
    logic [3:0]  e_rsp;
    logic        e_busy;
    logic [15:0] e_pow;
  } vec_t;

  vec_t vecs [14];

  logic        en_s   [12];
  logic [3:0]  rdy_s  [12];
  logic [3:0]  rsp_s  [12];
  logic [15:0] pow_s  [12];

  initial begin
    rst = 1'b1; en = 1'b1; req_valid = '0; rsp_ready = 4'hF; req_x = '0;

    // Single requester, then four-way round robin.
    vecs[0]  = '{1'b1, 1'b1, 4'h0, 4'hF, 16'h0000, 4'h0, 1'b1, 4'h0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 4'h1, 4'hF, 16'h0000, 4'h1, 1'b1, 4'h0, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 4'h0, 4'hF, 16'h0000, 4'h0, 1'b1, 4'h0, 1'b1, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 4'h0, 4'hF, 16'h0000, 4'h0, 1'b1, 4'h1, 1'b1, 16'h0400};
    vecs[4]  = '{1'b0, 1'b1, 4'h0, 4'hF, 16'h0000, 4'h0, 1'b1, 4'h0, 1'b0, 16'h0000};
    vecs[5]  = '{1'b1, 1'b1, 4'h0, 4'hF, 16'h1400, 4'h0, 1'b1, 4'h0, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 4'hF, 4'hF, 16'h1400, 4'h1, 1'b1, 4'h0, 1'b0, 16'h0000};
    vecs[7]  = '{1'b0, 1'b1, 4'hF, 4'hF, 16'h1400, 4'h2, 1'b1, 4'h0, 1'b1, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 4'hF, 4'hF, 16'h1400, 4'h4, 1'b1, 4'h1, 1'b1, 16'h8000};
    vecs[9]  = '{1'b0, 1'b1, 4'hF, 4'hF, 16'h1400, 4'h8, 1'b1, 4'h2, 1'b1, 16'h8000};
    vecs[10] = '{1'b0, 1'b1, 4'hF, 4'hF, 16'h1400, 4'h1, 1'b1, 4'h4, 1'b1, 16'h8000};
    vecs[11] = '{1'b0, 1'b1, 4'h0, 4'hF, 16'h1400, 4'h0, 1'b1, 4'h8, 1'b1, 16'h8000};
    vecs[12] = '{1'b0, 1'b1, 4'h0, 4'hF, 16'h1400, 4'h0, 1'b1, 4'h1, 1'b1, 16'h8000};
    vecs[13] = '{1'b0, 1'b1, 4'h0, 4'hF, 16'h1400, 4'h0, 1'b1, 4'h0, 1'b0, 16'h0000};

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; en = vecs[i].en; req_valid = vecs[i].req;
      rsp_ready = vecs[i].rdy; req_x = {4{vecs[i].x}};
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
      chk($sformatf("tbl%0d_pu_valid", i), 32'(pu_valid_o), 32'(|vecs[i].e_ready));
      chk($sformatf("tbl%0d_pu_en", i), 32'(pu_en), 32'(vecs[i].e_pu_en));
      chk($sformatf("tbl%0d_rsp", i), 32'(rsp_valid), 32'(vecs[i].e_rsp));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_rsp != 4'h0) begin
        chk($sformatf("tbl%0d_pow", i), 32'(rsp_pow), 32'(vecs[i].e_pow));
        chk($sformatf("tbl%0d_byp", i), 32'(rsp_x), 32'(vecs[i].x));
      end
    end

    // Sink 2 back-pressure with its result parked at the tail.
    req_x = {16'h0000, 16'h0800, 16'h0000, 16'h0000};
    step(1'b1, 1'b1, 4'h0, 4'hF);
    step(1'b0, 1'b1, 4'h4, 4'hB);
    chk("bp_grant2", 32'(req_ready), 32'h4);
    step(1'b0, 1'b1, 4'h0, 4'hB);
    chk("bp_rsp_early", 32'(rsp_valid), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 4'h1, 4'hB);
      chk($sformatf("bp_stall%0d_pu_en", i), 32'(pu_en), 32'h0);
      chk($sformatf("bp_stall%0d_ready", i), 32'(req_ready), 32'h0);
      chk($sformatf("bp_stall%0d_rsp", i), 32'(rsp_valid), 32'h4);
      chk($sformatf("bp_stall%0d_pow", i), 32'(rsp_pow), 32'h1000);
      chk($sformatf("bp_stall%0d_byp", i), 32'(rsp_x), 32'h0800);
    end
    step(1'b0, 1'b1, 4'h1, 4'hF);
    chk("bp_release_pu_en", 32'(pu_en), 32'h1);
    chk("bp_release_rsp", 32'(rsp_valid), 32'h4);
    chk("bp_release_grant0", 32'(req_ready), 32'h1);
    step(1'b0, 1'b1, 4'h0, 4'hF);
    chk("bp_gap_rsp", 32'(rsp_valid), 32'h0);
    step(1'b0, 1'b1, 4'h0, 4'hF);
    chk("bp_req0_rsp", 32'(rsp_valid), 32'h1);
    chk("bp_req0_pow", 32'(rsp_pow), 32'h0400);
    step(1'b0, 1'b1, 4'h0, 4'hF);
    chk("bp_idle_busy", 32'(busy), 32'h0);

    // Global enable low for three cycles mid-stream.
    req_x = {16'h0C00, 16'h0800, 16'h0400, 16'h0000};
    en_s  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    rdy_s = '{4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    rsp_s = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0};
    pow_s = '{16'h0, 16'h0, 16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0800,
              16'h1000, 16'h2000, 16'h0400, 16'h0, 16'h0};
    step(1'b1, 1'b1, 4'h0, 4'hF);
    for (int c = 0; c < 12; c++) begin
      step(1'b0, en_s[c], (c < 8) ? 4'hF : 4'h0, 4'hF);
      chk($sformatf("en%0d_ready", c), 32'(req_ready), 32'(rdy_s[c]));
      chk($sformatf("en%0d_pu_en", c), 32'(pu_en), 32'(en_s[c]));
      chk($sformatf("en%0d_rsp", c), 32'(rsp_valid), 32'(rsp_s[c]));
      if (rsp_s[c] != 4'h0) chk($sformatf("en%0d_pow", c), 32'(rsp_pow), 32'(pow_s[c]));
      if (c == 3) chk("en_frozen_busy", 32'(busy), 32'h1);
    end
    chk("en_end_busy", 32'(busy), 32'h0);

    // Reset with two operands in flight.
    req_x = '0;
    step(1'b1, 1'b1, 4'h0, 4'hF);
    step(1'b0, 1'b1, 4'hF, 4'hF);
    chk("rst_g0", 32'(req_ready), 32'h1);
    step(1'b0, 1'b1, 4'hF, 4'hF);
    chk("rst_g1", 32'(req_ready), 32'h2);
    step(1'b1, 1'b1, 4'h0, 4'hF);
    chk("rst_rsp", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_pu_valid", 32'(pu_valid_o), 32'h0);
    chk("rst_pu_en", 32'(pu_en), 32'h1);
    step(1'b0, 1'b1, 4'h0, 4'hF);
    chk("post_busy", 32'(busy), 32'h0);
    chk("post_rsp0", 32'(rsp_valid), 32'h0);
    step(1'b0, 1'b1, 4'hF, 4'hF);
    chk("post_grant0", 32'(req_ready), 32'h1);
    chk("post_rsp1", 32'(rsp_valid), 32'h0);
    step(1'b0, 1'b1, 4'h0, 4'hF);
    chk("post_rsp2", 32'(rsp_valid), 32'h0);
    step(1'b0, 1'b1, 4'h0, 4'hF);
    chk("post_rsp3", 32'(rsp_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
